// File: rtl/axi_fifo_rd_rsv.sv
// AXI4 read-channel FIFO that forwards an AR only once FIFO space for the
// whole burst is reserved, so the downstream R channel never sees back-pressure.
module axi_fifo_rd_rsv #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [CW-1:0]         status_fifo_count,
    output logic [CW-1:0]         status_reserved,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] status_outstanding,
    output logic                  status_ar_stall
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = CW - 1;
    localparam int EW = ID_WIDTH + DATA_WIDTH + 3;
    localparam int LW = (CW > 9) ? CW : 9;

    // AR output register
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [2:0]            arprot_q, arprot_d;
    logic                  arvalid_q, arvalid_d;

    // FIFO and credit state
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [CW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         rsv_q, rsv_d;
    logic [OW-1:0]         ost_q, ost_d;
    logic                  init_q;

    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic [LW-1:0]         len1;
    logic [CW-1:0]         need;
    logic [CW+1:0]         demand;
    logic                  fit;
    logic                  ost_ok;
    logic                  credit_ok;
    logic                  ar_hs;
    logic                  wr_en;
    logic                  rd_en;
    logic [EW-1:0]         head;

    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[CW-1] != rptr_q[CW-1]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A burst longer than the FIFO only needs to reserve the whole FIFO;
    // the tail beats are then paced by the full flag.
    assign len1 = LW'(s_axi_arlen) + LW'(1);
    assign need = (len1 > LW'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : CW'(len1);

    assign demand    = (CW+2)'(count) + (CW+2)'(rsv_q) + (CW+2)'(need);
    assign fit       = (demand <= (CW+2)'(FIFO_DEPTH));
    assign ost_ok    = (ost_q < OW'(MAX_OUTSTANDING));
    assign credit_ok = fit && ost_ok;

    assign s_axi_arready = init_q && credit_ok &&
                           (!arvalid_q || m_axi_arready);
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign m_axi_rready = init_q && !full;
    assign wr_en = m_axi_rvalid && m_axi_rready;
    assign rd_en = !empty && s_axi_rready;

    always_comb begin
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        if (ar_hs) begin
            arid_d    = s_axi_arid;
            araddr_d  = s_axi_araddr;
            arlen_d   = s_axi_arlen;
            arsize_d  = s_axi_arsize;
            arburst_d = s_axi_arburst;
            arprot_d  = s_axi_arprot;
            arvalid_d = 1'b1;
        end else if (m_axi_arready) begin
            arvalid_d = 1'b0;
        end
    end

    always_comb begin
        wptr_d = wptr_q + (wr_en ? CW'(1) : CW'(0));
        rptr_d = rptr_q + (rd_en ? CW'(1) : CW'(0));
        rsv_d  = rsv_q + (ar_hs ? need : CW'(0))
                       - ((wr_en && rsv_q != '0) ? CW'(1) : CW'(0));
        ost_d  = ost_q + (ar_hs ? OW'(1) : OW'(0))
                       - ((wr_en && m_axi_rlast && ost_q != '0) ?
                          OW'(1) : OW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rsv_q     <= '0;
            ost_q     <= '0;
            init_q    <= 1'b0;
        end else begin
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rsv_q     <= rsv_d;
            ost_q     <= ost_d;
            init_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= {m_axi_rid, m_axi_rdata,
                                      m_axi_rresp, m_axi_rlast};
        end
    end

    // Payload is masked while empty so stale storage never leaks out.
    assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    assign s_axi_rvalid = !empty;
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = head;

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arprot  = arprot_q;
    assign m_axi_arvalid = arvalid_q;

    assign status_fifo_count  = count;
    assign status_reserved    = rsv_q;
    assign status_outstanding = ost_q;
    assign status_ar_stall    = s_axi_arvalid && !credit_ok;

endmodule

// File: tb/tb_axi_fifo_rd_rsv.sv
// Directed bench for axi_fifo_rd_rsv: three instances cover depth 64,
// depth 16 and an outstanding cap of 2.
module tb_axi_fifo_rd_rsv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  s_arid [3];
    logic [31:0] s_araddr [3];
    logic [7:0]  s_arlen [3];
    logic        s_arvalid [3];
    logic        s_arready [3];
    logic [7:0]  s_rid [3];
    logic [31:0] s_rdata [3];
    logic [1:0]  s_rresp [3];
    logic        s_rlast [3];
    logic        s_rvalid [3];
    logic        s_rready [3];
    logic [7:0]  m_arid [3];
    logic [31:0] m_araddr [3];
    logic [7:0]  m_arlen [3];
    logic [2:0]  m_arsize [3];
    logic [1:0]  m_arburst [3];
    logic [2:0]  m_arprot [3];
    logic        m_arvalid [3];
    logic        m_arready [3];
    logic [7:0]  m_rid [3];
    logic [31:0] m_rdata [3];
    logic [1:0]  m_rresp [3];
    logic        m_rlast [3];
    logic        m_rvalid [3];
    logic        m_rready [3];
    logic [7:0]  st_fc [3];
    logic [7:0]  st_rs [3];
    logic [7:0]  st_os [3];
    logic        st_stall [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DEP = (g == 0) ? 64 : 16;
        localparam int MO  = (g == 2) ? 2 : 4;
        localparam int CWG = $clog2(DEP) + 1;
        localparam int OWG = $clog2(MO + 1);
        logic [CWG-1:0] fc_w;
        logic [CWG-1:0] rs_w;
        logic [OWG-1:0] os_w;
        assign st_fc[g] = 8'(fc_w);
        assign st_rs[g] = 8'(rs_w);
        assign st_os[g] = 8'(os_w);

        axi_fifo_rd_rsv #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8),
            .FIFO_DEPTH(DEP), .MAX_OUTSTANDING(MO)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_axi_arid(s_arid[g]), .s_axi_araddr(s_araddr[g]),
            .s_axi_arlen(s_arlen[g]), .s_axi_arsize(3'd2),
            .s_axi_arburst(2'b01), .s_axi_arprot(3'd0),
            .s_axi_arvalid(s_arvalid[g]), .s_axi_arready(s_arready[g]),
            .s_axi_rid(s_rid[g]), .s_axi_rdata(s_rdata[g]),
            .s_axi_rresp(s_rresp[g]), .s_axi_rlast(s_rlast[g]),
            .s_axi_rvalid(s_rvalid[g]), .s_axi_rready(s_rready[g]),
            .m_axi_arid(m_arid[g]), .m_axi_araddr(m_araddr[g]),
            .m_axi_arlen(m_arlen[g]), .m_axi_arsize(m_arsize[g]),
            .m_axi_arburst(m_arburst[g]), .m_axi_arprot(m_arprot[g]),
            .m_axi_arvalid(m_arvalid[g]), .m_axi_arready(m_arready[g]),
            .m_axi_rid(m_rid[g]), .m_axi_rdata(m_rdata[g]),
            .m_axi_rresp(m_rresp[g]), .m_axi_rlast(m_rlast[g]),
            .m_axi_rvalid(m_rvalid[g]), .m_axi_rready(m_rready[g]),
            .status_fifo_count(fc_w), .status_reserved(rs_w),
            .status_outstanding(os_w), .status_ar_stall(st_stall[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 3; d++) begin
            s_arid[d] = '0; s_araddr[d] = '0; s_arlen[d] = '0;
            s_arvalid[d] = 1'b0; s_rready[d] = 1'b0;
            m_arready[d] = 1'b0; m_rid[d] = '0; m_rdata[d] = '0;
            m_rresp[d] = '0; m_rlast[d] = 1'b0; m_rvalid[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int in_i;
        int out_i;
        int cyc;
        logic wr;
        logic rdh;

        // reset state
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_arready%0d", d), 32'(s_arready[d]), 0);
            chk($sformatf("rst_rready%0d", d), 32'(m_rready[d]), 0);
            chk($sformatf("rst_marvalid%0d", d), 32'(m_arvalid[d]), 0);
            chk($sformatf("rst_rvalid%0d", d), 32'(s_rvalid[d]), 0);
            chk($sformatf("rst_fc%0d", d), 32'(st_fc[d]), 0);
            chk($sformatf("rst_rs%0d", d), 32'(st_rs[d]), 0);
            chk($sformatf("rst_os%0d", d), 32'(st_os[d]), 0);
            chk($sformatf("rst_stall%0d", d), 32'(st_stall[d]), 0);
        end
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("run_arready%0d", d), 32'(s_arready[d]), 1);
            chk($sformatf("run_rready%0d", d), 32'(m_rready[d]), 1);
        end

        // single burst, depth 64
        s_arvalid[0] = 1'b1; s_arid[0] = 8'd5;
        s_araddr[0] = 32'h1000; s_arlen[0] = 8'd7;
        chk("t1_arready", 32'(s_arready[0]), 1);
        tick();
        s_arvalid[0] = 1'b0;
        chk("t1_marvalid", 32'(m_arvalid[0]), 1);
        chk("t1_maraddr", m_araddr[0], 32'h1000);
        chk("t1_marlen", 32'(m_arlen[0]), 7);
        chk("t1_marid", 32'(m_arid[0]), 5);
        chk("t1_marsize", 32'(m_arsize[0]), 2);
        chk("t1_marburst", 32'(m_arburst[0]), 1);
        chk("t1_marprot", 32'(m_arprot[0]), 0);
        chk("t1_rs", 32'(st_rs[0]), 8);
        chk("t1_os", 32'(st_os[0]), 1);
        m_arready[0] = 1'b1;
        tick();
        m_arready[0] = 1'b0;
        chk("t1_marvalid_done", 32'(m_arvalid[0]), 0);
        for (int i = 0; i < 8; i++) begin
            m_rvalid[0] = 1'b1; m_rid[0] = 8'd5;
            m_rdata[0] = 32'hA0 + 32'(i); m_rlast[0] = (i == 7);
            chk("t1_mrready", 32'(m_rready[0]), 1);
            tick();
        end
        m_rvalid[0] = 1'b0; m_rlast[0] = 1'b0;
        chk("t1_fc8", 32'(st_fc[0]), 8);
        chk("t1_rs0", 32'(st_rs[0]), 0);
        chk("t1_os0", 32'(st_os[0]), 0);
        s_rready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t1_rvalid", 32'(s_rvalid[0]), 1);
            chk("t1_rdata", s_rdata[0], 32'hA0 + 32'(i));
            chk("t1_rlast", 32'(s_rlast[0]), 32'(i == 7));
            chk("t1_rid", 32'(s_rid[0]), 5);
            chk("t1_rresp", 32'(s_rresp[0]), 0);
            tick();
        end
        s_rready[0] = 1'b0;
        chk("t1_empty", 32'(s_rvalid[0]), 0);
        chk("t1_fc0", 32'(st_fc[0]), 0);

        // reset mid-burst
        s_arvalid[0] = 1'b1; s_arlen[0] = 8'd7; s_araddr[0] = 32'h2000;
        tick();
        s_arvalid[0] = 1'b0; m_arready[0] = 1'b1;
        tick();
        m_arready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_rvalid[0] = 1'b1; m_rdata[0] = 32'hB0 + 32'(i);
            tick();
        end
        m_rvalid[0] = 1'b0;
        chk("mb_fc3", 32'(st_fc[0]), 3);
        chk("mb_rs5", 32'(st_rs[0]), 5);
        chk("mb_os1", 32'(st_os[0]), 1);
        rst = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mb_marvalid%0d", d), 32'(m_arvalid[d]), 0);
            chk($sformatf("mb_rvalid%0d", d), 32'(s_rvalid[d]), 0);
            chk($sformatf("mb_rdata%0d", d), s_rdata[d], 0);
            chk($sformatf("mb_fc%0d", d), 32'(st_fc[d]), 0);
            chk($sformatf("mb_rs%0d", d), 32'(st_rs[d]), 0);
            chk($sformatf("mb_os%0d", d), 32'(st_os[d]), 0);
            chk($sformatf("mb_stall%0d", d), 32'(st_stall[d]), 0);
        end
        rst = 1'b0;
        tick();

        // credit stall, depth 16
        m_arready[1] = 1'b1;
        s_arvalid[1] = 1'b1; s_arid[1] = 8'd1; s_arlen[1] = 8'd7;
        chk("cs_ar1", 32'(s_arready[1]), 1);
        tick();
        s_arid[1] = 8'd2;
        chk("cs_ar2", 32'(s_arready[1]), 1);
        tick();
        chk("cs_rs16", 32'(st_rs[1]), 16);
        chk("cs_os2", 32'(st_os[1]), 2);
        s_arid[1] = 8'd3; s_arlen[1] = 8'd0;
        chk("cs_ar3_blocked", 32'(s_arready[1]), 0);
        chk("cs_stall", 32'(st_stall[1]), 1);
        tick();
        chk("cs_ar3_still", 32'(s_arready[1]), 0);
        chk("cs_stall2", 32'(st_stall[1]), 1);
        chk("cs_marvalid0", 32'(m_arvalid[1]), 0);
        m_rvalid[1] = 1'b1; m_rdata[1] = 32'h11;
        tick();
        m_rvalid[1] = 1'b0;
        chk("cs_fc1", 32'(st_fc[1]), 1);
        chk("cs_rs15", 32'(st_rs[1]), 15);
        chk("cs_stall3", 32'(st_stall[1]), 1);
        s_rready[1] = 1'b1;
        chk("cs_pop_data", s_rdata[1], 32'h11);
        tick();
        s_rready[1] = 1'b0;
        chk("cs_fc0", 32'(st_fc[1]), 0);
        chk("cs_ar3_ready", 32'(s_arready[1]), 1);
        chk("cs_stall_clr", 32'(st_stall[1]), 0);
        tick();
        s_arvalid[1] = 1'b0;
        chk("cs_rs_after", 32'(st_rs[1]), 16);
        chk("cs_os3", 32'(st_os[1]), 3);
        chk("cs_marvalid3", 32'(m_arvalid[1]), 1);
        chk("cs_marid3", 32'(m_arid[1]), 3);
        do_reset();

        // backpressure, depth 16
        s_arvalid[1] = 1'b1; s_arid[1] = 8'd7; s_arlen[1] = 8'd15;
        tick();
        s_arvalid[1] = 1'b0;
        chk("bp_rs16", 32'(st_rs[1]), 16);
        for (int i = 0; i < 16; i++) begin
            m_rvalid[1] = 1'b1; m_rid[1] = 8'd7;
            m_rdata[1] = 32'h100 + 32'(i); m_rlast[1] = (i == 15);
            chk("bp_mrready", 32'(m_rready[1]), 1);
            tick();
        end
        m_rdata[1] = 32'hDEAD; m_rlast[1] = 1'b0;
        chk("bp_full_ready", 32'(m_rready[1]), 0);
        chk("bp_fc16", 32'(st_fc[1]), 16);
        chk("bp_rs0", 32'(st_rs[1]), 0);
        chk("bp_os0", 32'(st_os[1]), 0);
        tick();
        chk("bp_fc_hold", 32'(st_fc[1]), 16);
        chk("bp_stable1", s_rdata[1], 32'h100);
        tick();
        chk("bp_stable2", s_rdata[1], 32'h100);
        chk("bp_stable_id", 32'(s_rid[1]), 7);
        m_rvalid[1] = 1'b0;
        s_rready[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain", s_rdata[1], 32'h100 + 32'(i));
            tick();
        end
        s_rready[1] = 1'b0;
        chk("bp_empty", 32'(s_rvalid[1]), 0);
        do_reset();

        // oversize burst, depth 16
        s_arvalid[1] = 1'b1; s_arlen[1] = 8'd31;
        tick();
        s_arvalid[1] = 1'b0;
        chk("ov_rs16", 32'(st_rs[1]), 16);
        chk("ov_marlen", 32'(m_arlen[1]), 31);
        for (int i = 0; i < 16; i++) begin
            m_rvalid[1] = 1'b1; m_rdata[1] = 32'h200 + 32'(i);
            m_rlast[1] = 1'b0;
            chk("ov_mrready", 32'(m_rready[1]), 1);
            tick();
        end
        in_i = 16;
        m_rdata[1] = 32'h210;
        chk("ov_throttle", 32'(m_rready[1]), 0);
        chk("ov_fc16", 32'(st_fc[1]), 16);
        chk("ov_rs0", 32'(st_rs[1]), 0);
        chk("ov_os1", 32'(st_os[1]), 1);
        tick();
        chk("ov_fc_hold", 32'(st_fc[1]), 16);
        s_rready[1] = 1'b1;
        out_i = 0;
        cyc = 0;
        while (out_i < 32 && cyc < 200) begin
            m_rvalid[1] = (in_i < 32);
            m_rdata[1] = 32'h200 + 32'(in_i);
            m_rlast[1] = (in_i == 31);
            wr = m_rvalid[1] && m_rready[1];
            rdh = s_rvalid[1];
            if (rdh) begin
                chk("ov_data", s_rdata[1], 32'h200 + 32'(out_i));
                chk("ov_last", 32'(s_rlast[1]), 32'(out_i == 31));
            end
            tick();
            if (wr) in_i++;
            if (rdh) out_i++;
            cyc++;
        end
        s_rready[1] = 1'b0; m_rvalid[1] = 1'b0; m_rlast[1] = 1'b0;
        chk("ov_done", 32'(out_i), 32);
        chk("ov_sent", 32'(in_i), 32);
        chk("ov_fc0", 32'(st_fc[1]), 0);
        chk("ov_os0", 32'(st_os[1]), 0);
        do_reset();

        // outstanding cap of 2
        m_arready[2] = 1'b1;
        s_arvalid[2] = 1'b1; s_arid[2] = 8'd1; s_arlen[2] = 8'd0;
        tick();
        chk("oc_marid1", 32'(m_arid[2]), 1);
        chk("oc_os1", 32'(st_os[2]), 1);
        s_arid[2] = 8'd2;
        chk("oc_ar2", 32'(s_arready[2]), 1);
        tick();
        chk("oc_marid2", 32'(m_arid[2]), 2);
        chk("oc_os2", 32'(st_os[2]), 2);
        s_arid[2] = 8'd3;
        chk("oc_ar3_blocked", 32'(s_arready[2]), 0);
        chk("oc_stall", 32'(st_stall[2]), 1);
        tick();
        chk("oc_marvalid0", 32'(m_arvalid[2]), 0);
        chk("oc_os_hold", 32'(st_os[2]), 2);
        chk("oc_ar3_still", 32'(s_arready[2]), 0);
        m_rvalid[2] = 1'b1; m_rid[2] = 8'd1;
        m_rlast[2] = 1'b1; m_rdata[2] = 32'h31;
        chk("oc_ar3_wr_cycle", 32'(s_arready[2]), 0);
        tick();
        m_rvalid[2] = 1'b0; m_rlast[2] = 1'b0;
        chk("oc_os_dec", 32'(st_os[2]), 1);
        chk("oc_ar3_ready", 32'(s_arready[2]), 1);
        chk("oc_stall_clr", 32'(st_stall[2]), 0);
        tick();
        s_arvalid[2] = 1'b0;
        chk("oc_marvalid3", 32'(m_arvalid[2]), 1);
        chk("oc_marid3", 32'(m_arid[2]), 3);
        chk("oc_os_final", 32'(st_os[2]), 2);
        chk("oc_rs_final", 32'(st_rs[2]), 2);
        chk("oc_fc_final", 32'(st_fc[2]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_fifo_rd_rsv.md
Name: axi_fifo_rd_rsv

Overview:
Parametrised successor to the read half of the AXI FIFO. It buffers AXI4 read data in a FIFO of configurable depth and width. A read address is issued downstream only once FIFO space is reserved for its whole burst, and the number of outstanding bursts is capped. Occupancy, reservation and stall status are exposed. It sits between an AXI master and the interconnect/slave port, so the downstream slave is never back-pressured on R for reserved bursts.

Parameters:
DATA_WIDTH, 32, R data width in bits
ADDR_WIDTH, 32, address width
ID_WIDTH, 8, ARID/RID width
FIFO_DEPTH, 64, R FIFO depth in beats; power of 2, >= 2
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete read bursts; >= 1
CW, $clog2(FIFO_DEPTH)+1, width of the occupancy counters (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_arid/araddr/arlen/arsize/arburst/arprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/3  slave AR payload
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  slave R payload
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
m_axi_arid/araddr/arlen/arsize/arburst/arprot  out  same as slave  master AR payload, registered
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid/rdata/rresp/rlast  in  same as slave  master R payload
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
status_fifo_count  out  CW  beats held in the FIFO
status_reserved  out  CW  beats reserved but not yet received
status_outstanding  out  $clog2(MAX_OUTSTANDING+1)  bursts outstanding
status_ar_stall  out  1  AR valid but blocked by credit

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset clears all state and discards FIFO contents. All outputs read 0 after reset: valids, readies, payload registers, status counts and stall. Reset mid-burst discards the burst with no recovery; the bench must also reset the neighbours.
- Definitions:
  - need = min(arlen+1, FIFO_DEPTH).
  - free = FIFO_DEPTH - fifo_count - reserved.
  - credit_ok = (free >= need) && (outstanding < MAX_OUTSTANDING).
- AR register:
  - One-entry output register. s_axi_arready = credit_ok && (!m_axi_arvalid || m_axi_arready).
  - s_axi_arready is combinational from state and m_axi_arready only, never from s_axi_arvalid.
  - On an s AR handshake, the payload is copied to the m AR register and m_axi_arvalid is set next cycle. The register holds stable until the m handshake.
- Counters on an s AR handshake:
  - reserved += need.
  - outstanding += 1.
- R path:
  - m_axi_rready = (fifo_count < FIFO_DEPTH). It is registered-state only and never waits on s_axi_rready.
  - A beat is written on m_axi_rvalid && m_axi_rready.
  - Each write decrements reserved by 1 if reserved > 0. Writes with reserved == 0 occur only when a burst is longer than FIFO_DEPTH; the FIFO full flag then throttles.
  - A write with rlast decrements outstanding.
- FIFO:
  - Circular buffer with CW-bit read/write pointers; full/empty use MSB-differs compare.
  - A beat written in cycle N is presented on s_axi_r* in cycle N+1 or later, in order.
  - s R outputs stay stable while s_axi_rvalid && !s_axi_rready.
  - Simultaneous read and write on a full FIFO: the write is refused because ready is derived from the current count; the read proceeds.
  - Simultaneous read and write on an empty FIFO: the beat appears next cycle.
- Simultaneous events: counters take the net effect in one cycle, e.g. an AR accept plus an rlast write leaves outstanding unchanged, and reserved += need-1.
- Status:
  - status_* reflect registered counter values.
  - status_ar_stall = s_axi_arvalid && !credit_ok.
- Ordering: no ID reordering; all traffic passes through in order.

Test Plan:
- Single burst, DEPTH=64: AR arlen=7 -> m AR next cycle, reserved=8, outstanding=1. Slave returns 8 beats -> reserved 0, outstanding 0, master receives 8 beats with rlast on beat 8.
- Credit stall, DEPTH=16: two AR arlen=7 accepted, third arlen=0 held -> status_ar_stall=1 and s_axi_arready=0 until the master pops 1 beat, then accepted.
- Outstanding cap, MAX_OUTSTANDING=2: three AR arlen=0 with R withheld -> only 2 forwarded. The 3rd is accepted the cycle after the first rlast write.
- Backpressure: s_axi_rready=0 with 16 reserved beats, DEPTH=16 -> m_axi_rready stays 1 for all 16, then 0. Releasing s_axi_rready drains in order and payload stays stable while stalled.
- Oversize burst, DEPTH=16: arlen=31 -> reserves 16. Beats 17-32 are throttled by full while s_axi_rready is low, and data integrity holds.
- Reset mid-burst: assert rst after 3 of 8 beats -> next cycle all valids 0 and all status 0.
